// File: rtl/dag_pkg.sv
// Shared definitions for the data address generators: universal-register
// address map and register-file geometry.
package dag_pkg;

    localparam int DAG_REGS  = 8;
    localparam int DAG_IDX_W = 3;

    // Universal register address = {group, index}
    typedef enum logic [1:0] {
        GRP_I = 2'b00,
        GRP_M = 2'b01,
        GRP_L = 2'b10,
        GRP_B = 2'b11
    } dag_grp_e;

    function automatic dag_grp_e ureg_grp(input logic [DAG_IDX_W+1:0] add);
        return dag_grp_e'(add[DAG_IDX_W+1:DAG_IDX_W]);
    endfunction

    function automatic logic [DAG_IDX_W-1:0] ureg_idx(input logic [DAG_IDX_W+1:0] add);
        return add[DAG_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/dag_circ_update.sv
// Circular-buffer index update: next I = I + sext(M), folded back into
// [B, B+L) with a single correction when L is non-zero.
module dag_circ_update #(
    parameter int DMA_SIZE = 17,
    parameter int DMD_SIZE = 16
) (
    input  logic [DMA_SIZE-1:0] i_val,
    input  logic [DMD_SIZE-1:0] m_val,
    input  logic [DMA_SIZE-1:0] l_val,
    input  logic [DMA_SIZE-1:0] b_val,
    output logic [DMA_SIZE-1:0] next_i
);

    // Two guard bits: one for the sign of I+M, one so B+L and I+M cannot
    // overflow when I sits near the top of the address space.
    localparam int W = DMA_SIZE + 2;

    logic signed [W-1:0] sum;
    logic signed [W-1:0] lo;
    logic signed [W-1:0] hi;
    logic signed [W-1:0] len;
    logic signed [W-1:0] corr;
    logic                corr_unused;

    assign sum = $signed({2'b00, i_val}) + $signed({{(W-DMD_SIZE){m_val[DMD_SIZE-1]}}, m_val});
    assign lo  = $signed({2'b00, b_val});
    assign len = $signed({2'b00, l_val});
    assign hi  = lo + len;

    // Single wrap correction; L = 0 leaves the sum to wrap modulo 2^DMA_SIZE
    always_comb begin
        corr = sum;
        if (l_val != '0) begin
            if (sum >= hi)
                corr = sum - len;
            else if (sum < lo)
                corr = sum + len;
        end
    end

    assign next_i      = corr[DMA_SIZE-1:0];
    assign corr_unused = ^corr[W-1:DMA_SIZE];

endmodule

// File: rtl/dag_dm.sv
// Data-memory address generator: eight I/M/L/B register sets, pre/post
// modify addressing with circular wrap, and universal-register access.
module dag_dm
    import dag_pkg::*;
#(
    parameter int DMA_SIZE = 17,
    parameter int DMD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps_dg_en,
    input  logic                 ps_dg_pre,
    input  logic [2:0]           ps_dg_i_sel,
    input  logic [2:0]           ps_dg_m_sel,
    input  logic                 ps_dg_wrt_en,
    input  logic [4:0]           ps_dg_wrt_add,
    input  logic                 ps_dg_rd_en,
    input  logic [4:0]           ps_dg_rd_add,
    input  logic [DMD_SIZE-1:0]  bc_dt,
    output logic [DMA_SIZE-1:0]  dg_dm_add,
    output logic [DMD_SIZE-1:0]  dg_bc_dt
);

    logic [DMA_SIZE-1:0] i_reg [DAG_REGS];
    logic [DMD_SIZE-1:0] m_reg [DAG_REGS];
    logic [DMA_SIZE-1:0] l_reg [DAG_REGS];
    logic [DMA_SIZE-1:0] b_reg [DAG_REGS];

    logic [DMA_SIZE-1:0] i_cur;
    logic [DMD_SIZE-1:0] m_cur;
    logic [DMA_SIZE-1:0] m_ext;
    logic [DMA_SIZE-1:0] next_i;
    logic [DMD_SIZE-1:0] rd_val;
    logic [DMA_SIZE-1:0] wrt_zext;
    dag_grp_e            wrt_grp;
    dag_grp_e            rd_grp;
    logic [2:0]          wrt_idx;
    logic [2:0]          rd_idx;

    assign i_cur    = i_reg[ps_dg_i_sel];
    assign m_cur    = m_reg[ps_dg_m_sel];
    assign m_ext    = {{(DMA_SIZE-DMD_SIZE){m_cur[DMD_SIZE-1]}}, m_cur};
    assign wrt_zext = {{(DMA_SIZE-DMD_SIZE){1'b0}}, bc_dt};
    assign wrt_grp  = ureg_grp(ps_dg_wrt_add);
    assign wrt_idx  = ureg_idx(ps_dg_wrt_add);
    assign rd_grp   = ureg_grp(ps_dg_rd_add);
    assign rd_idx   = ureg_idx(ps_dg_rd_add);

    // Pre-modify presents I+M without wrap; otherwise the raw index
    assign dg_dm_add = (ps_dg_en && ps_dg_pre) ? (i_cur + m_ext) : i_cur;

    dag_circ_update #(
        .DMA_SIZE (DMA_SIZE),
        .DMD_SIZE (DMD_SIZE)
    ) u_circ (
        .i_val  (i_cur),
        .m_val  (m_cur),
        .l_val  (l_reg[ps_dg_i_sel]),
        .b_val  (b_reg[ps_dg_i_sel]),
        .next_i (next_i)
    );

    // Ureg read mux, low DMD_SIZE bits of the addressed register
    always_comb begin
        rd_val = '0;
        unique case (rd_grp)
            GRP_I: rd_val = i_reg[rd_idx][DMD_SIZE-1:0];
            GRP_M: rd_val = m_reg[rd_idx];
            GRP_L: rd_val = l_reg[rd_idx][DMD_SIZE-1:0];
            GRP_B: rd_val = b_reg[rd_idx][DMD_SIZE-1:0];
            default: rd_val = '0;
        endcase
    end

    // Register file update: post-modify first, ureg write last so it wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DAG_REGS; k++) begin
                i_reg[k] <= '0;
                m_reg[k] <= '0;
                l_reg[k] <= '0;
                b_reg[k] <= '0;
            end
            dg_bc_dt <= '0;
        end else begin
            if (ps_dg_en && !ps_dg_pre)
                i_reg[ps_dg_i_sel] <= next_i;
            if (ps_dg_wrt_en) begin
                unique case (wrt_grp)
                    GRP_I: i_reg[wrt_idx] <= wrt_zext;
                    GRP_M: m_reg[wrt_idx] <= bc_dt;
                    GRP_L: l_reg[wrt_idx] <= wrt_zext;
                    GRP_B: begin
                        b_reg[wrt_idx] <= wrt_zext;
                        i_reg[wrt_idx] <= wrt_zext;
                    end
                    default: ;
                endcase
            end
            if (ps_dg_rd_en)
                dg_bc_dt <= rd_val;
        end
    end

endmodule

// File: tb/tb_dag_dm.sv
// Self-checking bench for dag_dm with a behavioural register-file model.
module tb_dag_dm;

    localparam int MASK = 'h1FFFF;

    logic        clk;
    logic        reset;
    logic        ps_dg_en;
    logic        ps_dg_pre;
    logic [2:0]  ps_dg_i_sel;
    logic [2:0]  ps_dg_m_sel;
    logic        ps_dg_wrt_en;
    logic [4:0]  ps_dg_wrt_add;
    logic        ps_dg_rd_en;
    logic [4:0]  ps_dg_rd_add;
    logic [15:0] bc_dt;
    logic [16:0] dg_dm_add;
    logic [15:0] dg_bc_dt;

    int checks   = 0;
    int failures = 0;

    int mi [8];
    int mm [8];
    int ml [8];
    int mb [8];

    dag_dm dut (
        .clk           (clk),
        .reset         (reset),
        .ps_dg_en      (ps_dg_en),
        .ps_dg_pre     (ps_dg_pre),
        .ps_dg_i_sel   (ps_dg_i_sel),
        .ps_dg_m_sel   (ps_dg_m_sel),
        .ps_dg_wrt_en  (ps_dg_wrt_en),
        .ps_dg_wrt_add (ps_dg_wrt_add),
        .ps_dg_rd_en   (ps_dg_rd_en),
        .ps_dg_rd_add  (ps_dg_rd_add),
        .bc_dt         (bc_dt),
        .dg_dm_add     (dg_dm_add),
        .dg_bc_dt      (dg_bc_dt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int sext16(input int m);
        return (m >= 32768) ? m - 65536 : m;
    endfunction

    function automatic int model_next(input int i, input int m, input int l, input int b);
        int n;
        n = i + sext16(m);
        if (l != 0) begin
            if (n >= b + l) n = n - l;
            else if (n < b) n = n + l;
        end
        return n & MASK;
    endfunction

    function automatic int model_addr(input bit pre, input int i, input int m);
        return pre ? ((mi[i] + sext16(mm[m])) & MASK) : mi[i];
    endfunction

    function automatic int model_read(input int a);
        int k;
        k = a % 8;
        case (a / 8)
            0: return mi[k] & 'hFFFF;
            1: return mm[k] & 'hFFFF;
            2: return ml[k] & 'hFFFF;
            default: return mb[k] & 'hFFFF;
        endcase
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 8; k++) begin
            mi[k] = 0; mm[k] = 0; ml[k] = 0; mb[k] = 0;
        end
    endfunction

    function automatic void model_write(input int a, input int d);
        int k;
        k = a % 8;
        case (a / 8)
            0: mi[k] = d;
            1: mm[k] = d;
            2: ml[k] = d;
            default: begin mb[k] = d; mi[k] = d; end
        endcase
    endfunction

    task automatic ureg_write(input int a, input int d);
        ps_dg_wrt_en  = 1;
        ps_dg_wrt_add = 5'(a);
        bc_dt         = 16'(d);
        @(posedge clk); #1;
        ps_dg_wrt_en  = 0;
        model_write(a, d & 'hFFFF);
    endtask

    task automatic ureg_read(input int a, output logic [15:0] d);
        ps_dg_rd_en  = 1;
        ps_dg_rd_add = 5'(a);
        @(posedge clk); #1;
        ps_dg_rd_en  = 0;
        d = dg_bc_dt;
    endtask

    task automatic access(input bit pre, input int i, input int m, output logic [16:0] addr);
        ps_dg_en    = 1;
        ps_dg_pre   = pre;
        ps_dg_i_sel = 3'(i);
        ps_dg_m_sel = 3'(m);
        @(negedge clk);
        addr = dg_dm_add;
        @(posedge clk); #1;
        ps_dg_en = 0;
        if (!pre) mi[i] = model_next(mi[i], mm[m], ml[i], mb[i]);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        checks++;
        if (dg_dm_add !== 17'h0 || dg_bc_dt !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: add=%h bc_dt=%h required 0/0", dg_dm_add, dg_bc_dt);
        end
        for (int a = 0; a < 32; a += 7) begin
            ureg_read(a, d);
            checks++;
            if (d !== 16'h0) begin
                failures++;
                $display("FAIL reset_read[%0d]: got %h required 0000", a, d);
            end
        end
    endtask

    task automatic test_post_linear();
        logic [16:0] addr;
        int exp_a [3] = '{'h10, 'h13, 'h16};
        logic [15:0] d;
        ureg_write(0, 'h10);
        ureg_write(8, 3);
        ureg_write(16, 0);
        for (int n = 0; n < 3; n++) begin
            access(0, 0, 0, addr);
            checks++;
            if (addr !== 17'(exp_a[n])) begin
                failures++;
                $display("FAIL post_linear[%0d]: got %h required %h", n, addr, exp_a[n]);
            end
        end
        ureg_read(0, d);
        checks++;
        if (d !== 16'h19) begin
            failures++;
            $display("FAIL post_linear_final_i0: got %h required 0019", d);
        end
    endtask

    task automatic test_circ_up();
        logic [16:0] addr;
        int exp_a [5] = '{'h100, 'h102, 'h104, 'h101, 'h103};
        ureg_write(25, 'h100);
        ureg_write(17, 5);
        ureg_write(9, 2);
        for (int n = 0; n < 5; n++) begin
            access(0, 1, 1, addr);
            checks++;
            if (addr !== 17'(exp_a[n])) begin
                failures++;
                $display("FAIL circ_up[%0d]: got %h required %h", n, addr, exp_a[n]);
            end
        end
    endtask

    task automatic test_circ_down();
        logic [16:0] addr;
        int exp_a [5] = '{'h200, 'h203, 'h202, 'h201, 'h200};
        ureg_write(26, 'h200);
        ureg_write(18, 4);
        ureg_write(2, 'h200);
        ureg_write(10, 'hFFFF);
        for (int n = 0; n < 5; n++) begin
            access(0, 2, 2, addr);
            checks++;
            if (addr !== 17'(exp_a[n])) begin
                failures++;
                $display("FAIL circ_down[%0d]: got %h required %h", n, addr, exp_a[n]);
            end
        end
    endtask

    task automatic test_pre_modify();
        logic [16:0] addr;
        logic [15:0] d;
        ureg_write(3, 'h50);
        ureg_write(11, 'hFFF0);
        for (int n = 0; n < 2; n++) begin
            access(1, 3, 3, addr);
            checks++;
            if (addr !== 17'h40) begin
                failures++;
                $display("FAIL pre_modify[%0d]: got %h required 00040", n, addr);
            end
        end
        ureg_read(3, d);
        checks++;
        if (d !== 16'h50) begin
            failures++;
            $display("FAIL pre_modify_i3_kept: got %h required 0050", d);
        end
    endtask

    task automatic test_collision();
        logic [15:0] d;
        ureg_write(4, 'h20);
        ureg_write(12, 1);
        ps_dg_en      = 1;
        ps_dg_pre     = 0;
        ps_dg_i_sel   = 3'd4;
        ps_dg_m_sel   = 3'd4;
        ps_dg_wrt_en  = 1;
        ps_dg_wrt_add = 5'd4;
        bc_dt         = 16'h0080;
        @(posedge clk); #1;
        ps_dg_en     = 0;
        ps_dg_wrt_en = 0;
        mi[4] = 'h80;
        ureg_read(4, d);
        checks++;
        if (d !== 16'h0080) begin
            failures++;
            $display("FAIL collision_i4: got %h required 0080", d);
        end
        // Read and write of M4 in one cycle returns the old value
        ps_dg_rd_en   = 1;
        ps_dg_rd_add  = 5'd12;
        ps_dg_wrt_en  = 1;
        ps_dg_wrt_add = 5'd12;
        bc_dt         = 16'h1234;
        @(posedge clk); #1;
        ps_dg_rd_en  = 0;
        ps_dg_wrt_en = 0;
        mm[4] = 'h1234;
        checks++;
        if (dg_bc_dt !== 16'h0001) begin
            failures++;
            $display("FAIL rd_wr_same_m4: got %h required 0001", dg_bc_dt);
        end
        ureg_read(12, d);
        checks++;
        if (d !== 16'h1234) begin
            failures++;
            $display("FAIL m4_after_write: got %h required 1234", d);
        end
    endtask

    task automatic test_random();
        logic [16:0] addr;
        logic [15:0] d;
        int k, l, m, pre, exp;
        for (int r = 5; r < 8; r++) begin
            ureg_write(24 + r, $urandom_range(0, 'hF000));
            l = $urandom_range(0, 40);
            ureg_write(16 + r, l);
            if (l == 0) m = $urandom_range(0, 'hFFFF);
            else m = ($urandom_range(0, 2 * l) - l) & 'hFFFF;
            ureg_write(8 + r, m);
        end
        for (int n = 0; n < 40; n++) begin
            k   = $urandom_range(5, 7);
            pre = $urandom_range(0, 1);
            exp = model_addr(pre[0], k, k);
            access(pre[0], k, k, addr);
            checks++;
            if (addr !== 17'(exp)) begin
                failures++;
                $display("FAIL random_access[%0d] k=%0d pre=%0d: got %h required %h", n, k, pre, addr, exp);
            end
        end
        for (int a = 0; a < 32; a++) begin
            ureg_read(a, d);
            checks++;
            if (d !== 16'(model_read(a))) begin
                failures++;
                $display("FAIL random_read[%0d]: got %h required %h", a, d, model_read(a));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] d;
        ureg_read(0, d);
        ps_dg_en    = 1;
        ps_dg_pre   = 0;
        ps_dg_i_sel = 3'd1;
        ps_dg_m_sel = 3'd1;
        #2;
        reset = 0;
        #1;
        checks++;
        if (dg_dm_add !== 17'h0 || dg_bc_dt !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: add=%h bc_dt=%h required 0/0", dg_dm_add, dg_bc_dt);
        end
        ps_dg_en = 0;
        model_clear();
        @(posedge clk); #1;
        reset = 1;
        for (int a = 0; a < 32; a++) begin
            ureg_read(a, d);
            checks++;
            if (d !== 16'h0) begin
                failures++;
                $display("FAIL post_reset_read[%0d]: got %h required 0000", a, d);
            end
        end
    endtask

    initial begin
        reset         = 0;
        ps_dg_en      = 0;
        ps_dg_pre     = 0;
        ps_dg_i_sel   = 0;
        ps_dg_m_sel   = 0;
        ps_dg_wrt_en  = 0;
        ps_dg_wrt_add = 0;
        ps_dg_rd_en   = 0;
        ps_dg_rd_add  = 0;
        bc_dt         = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        test_reset();
        test_post_linear();
        test_circ_up();
        test_circ_down();
        test_pre_modify();
        test_collision();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
